snake_pixel_mapper: RTL and testbench
=====================================

// Module: snake_pixel_mapper
// PURPOSE
// Producer side of the colour-drawer interface. Holds the snake body state on a cell grid,
// advances it on move strobes, and flags game-over events. For every incoming VGA pixel
// coordinate, it generates the head, body, apple and border graphics flags and a delayed
// display_enable. These outputs feed the drawer directly and arrive aligned to each other.
// PARAMETERS
// CELL_PX   16  pixels per grid-cell side; must be a power of two
// GRID_W    40  grid width in cells (640 px / 16)
// GRID_H    30  grid height in cells (480 px / 16)
// MAX_LEN   16  segment storage depth (head included); length saturates here
// PORTS
// clk_i             in   1   pixel clock; the only clock
// rst_ni            in   1   synchronous reset, active-low
// pixel_x_i         in   10  current pixel column from the VGA timing block
// pixel_y_i         in   10  current pixel row
// display_enable_i  in   1   visible-area flag for pixel_x_i/pixel_y_i
// move_i            in   1   one-cycle strobe: advance snake by one cell
// dir_i             in   2   requested direction: 0=up 1=right 2=down 3=left
// grow_i            in   1   sampled with move_i: lengthen by one this move
// apple_x_i         in   6   apple cell column
// apple_y_i         in   6   apple cell row
// display_enable_o  out  1   display_enable_i delayed 2 cycles
// head_snake_gfx_o  out  1   pixel lies in the head cell
// body_snake_gfx_o  out  1   pixel lies in an active non-head segment
// apple_gfx_o       out  1   pixel lies in the apple cell
// border_gfx_o      out  1   pixel lies in the border ring (col 0 / GRID_W-1, row 0 / GRID_H-1)
// length_o          out  5   active segment count
// game_over_o       out  1   sticky; set on a wall hit or a self hit
// BEHAVIOUR
// - Reset (rst_ni=0 at a clock edge; wins over every other input):
//   - length=3; head=(GRID_W/2, GRID_H/2); body extends left at (x-1,y) and (x-2,y).
//   - dir=right; game_over_o=0; all gfx outputs and display_enable_o=0.
// - Render pipeline: fixed latency of 2 cycles, one pixel per cycle, no stalls.
//   - S1 registers cell_x=pixel_x>>log2(CELL_PX), cell_y=pixel_y>>log2(CELL_PX), a valid bit and the DE.
//   - S2 compares the S1 cell against the head, all segments with index<length, the apple
//     and the border ring, then registers the flags.
//   - All flags are forced 0 when the delayed DE is 0 or the pixel lies outside GRID_W*CELL_PX x GRID_H*CELL_PX.
//   - Flags are independent; overlap is allowed and the drawer applies priority.
// - Move, evaluated on a cycle with move_i=1 and game_over_o=0; move_i is ignored when game_over_o=1:
//   - Effective direction = dir_i, unless dir_i is the reverse of the current direction; then the current one is kept.
//   - next_head = head + direction step, computed in 7-bit signed arithmetic.
//   - Wall hit: next_head lands in the border ring -> game_over_o<=1, segments unchanged.
//   - Self hit: next_head equals segment k with 1<=k<length, excluding the tail (k=length-1)
//     when not growing -> game_over_o<=1, segments unchanged.
//   - Otherwise: seg[k]<=seg[k-1] for all k, seg[0]<=next_head, current dir<=effective dir.
//     If grow_i=1 and length<MAX_LEN, length<=length+1. At MAX_LEN, grow_i is ignored (no wrap).
// - Segment updates take effect the next cycle, even mid-frame; tearing within one frame is accepted.
// - Apple inputs are used live. They are not checked against the snake.
// CONFIGURATION
// - WRAP_AROUND_EN undefined:
//   - The border ring is drawn and is lethal, as above.
//   - The playfield is cells 1..GRID_W-2 x 1..GRID_H-2.
// - WRAP_AROUND_EN defined:
//   - border_gfx_o is tied to 0 and wall hits never occur.
//   - next_head wraps modulo GRID_W/GRID_H: col -1 -> GRID_W-1, col GRID_W -> 0, and the same for rows.
//   - Self hit still sets game_over_o.
// TESTING
// - Reset, then pixel (320,240) DE=1 -> 2 cycles later head_snake_gfx_o=1, display_enable_o=1; (300,240) -> body_snake_gfx_o=1.
// - Pixel (5,100) DE=1 -> border_gfx_o=1 after 2 cycles. The same pixel with DE=0 -> all flags 0.
// - apple=(3,4), pixel (48..63,64..79) -> apple_gfx_o=1; pixel (64,64) -> apple_gfx_o=0.
// - 3 moves with dir=1 and grow_i=1 on the second move -> head=(23,15), length_o=4; dir=3 then ignored, head=(24,15).
// - From reset, 18 moves right -> head reaches (38,15); the 19th move sets game_over_o=1; a further move_i leaves the head unchanged.
// - WRAP_AROUND_EN: 20 moves right from reset -> head=(0,15), game_over_o=0, border_gfx_o always 0.

Source files
------------

// File: rtl/snake_pixel_mapper_if.sv
// Pixel stream, game controls and graphics flags between the VGA/game side (master)
// and snake_pixel_mapper (slave).
interface snake_pixel_mapper_if;
  logic [9:0] pixel_x_i;
  logic [9:0] pixel_y_i;
  logic       display_enable_i;
  logic       move_i;
  logic [1:0] dir_i;
  logic       grow_i;
  logic [5:0] apple_x_i;
  logic [5:0] apple_y_i;
  logic       display_enable_o;
  logic       head_snake_gfx_o;
  logic       body_snake_gfx_o;
  logic       apple_gfx_o;
  logic       border_gfx_o;
  logic [4:0] length_o;
  logic       game_over_o;

  modport master (
    output pixel_x_i, pixel_y_i, display_enable_i, move_i, dir_i, grow_i,
           apple_x_i, apple_y_i,
    input  display_enable_o, head_snake_gfx_o, body_snake_gfx_o, apple_gfx_o,
           border_gfx_o, length_o, game_over_o
  );

  modport slave (
    input  pixel_x_i, pixel_y_i, display_enable_i, move_i, dir_i, grow_i,
           apple_x_i, apple_y_i,
    output display_enable_o, head_snake_gfx_o, body_snake_gfx_o, apple_gfx_o,
           border_gfx_o, length_o, game_over_o
  );
endinterface

// File: rtl/snake_pixel_mapper.sv
// Snake body state plus a 2-cycle pixel-to-graphics-flag pipeline for the colour drawer.
// Define WRAP_AROUND_EN to make the grid edges wrap instead of forming a lethal border.
module snake_pixel_mapper #(
  parameter int CELL_PX = 16,
  parameter int GRID_W  = 40,
  parameter int GRID_H  = 30,
  parameter int MAX_LEN = 16
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  snake_pixel_mapper_if.slave bus
);
  localparam int                SHIFT      = $clog2(CELL_PX);
  localparam logic [9:0]        PIX_W      = 10'(GRID_W * CELL_PX);
  localparam logic [9:0]        PIX_H      = 10'(GRID_H * CELL_PX);
  localparam logic [5:0]        LAST_COL   = 6'(GRID_W - 1);
  localparam logic [5:0]        LAST_ROW   = 6'(GRID_H - 1);
  localparam logic signed [6:0] LAST_COL_S = 7'(GRID_W - 1);
  localparam logic signed [6:0] LAST_ROW_S = 7'(GRID_H - 1);
  localparam logic [4:0]        MAX_LEN_L  = 5'(MAX_LEN);

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  logic [5:0]        seg_x [MAX_LEN];
  logic [5:0]        seg_y [MAX_LEN];
  logic [4:0]        length;
  dir_t              cur_dir;
  logic              game_over;

  dir_t              eff_dir;
  logic signed [6:0] step_x, step_y;
  logic [5:0]        next_x, next_y;
  logic              grow_eff, wall_hit, self_hit;

  // A reversal request would fold the head straight into the neck, so it is ignored.
  always_comb begin
    eff_dir = (bus.dir_i == (cur_dir ^ 2'd2)) ? cur_dir : dir_t'(bus.dir_i);
    step_x  = $signed({1'b0, seg_x[0]});
    step_y  = $signed({1'b0, seg_y[0]});
    case (eff_dir)
      DIR_UP:    step_y = step_y - 7'sd1;
      DIR_RIGHT: step_x = step_x + 7'sd1;
      DIR_DOWN:  step_y = step_y + 7'sd1;
      default:   step_x = step_x - 7'sd1;
    endcase
`ifdef WRAP_AROUND_EN
    wall_hit = 1'b0;
    if (step_x < 7'sd0)            next_x = LAST_COL;
    else if (step_x > LAST_COL_S)  next_x = 6'd0;
    else                           next_x = step_x[5:0];
    if (step_y < 7'sd0)            next_y = LAST_ROW;
    else if (step_y > LAST_ROW_S)  next_y = 6'd0;
    else                           next_y = step_y[5:0];
`else
    wall_hit = (step_x <= 7'sd0) || (step_x >= LAST_COL_S) ||
               (step_y <= 7'sd0) || (step_y >= LAST_ROW_S);
    next_x   = step_x[5:0];
    next_y   = step_y[5:0];
`endif
    grow_eff = bus.grow_i && (length < MAX_LEN_L);
    // The tail vacates its cell this move unless the snake is growing.
    self_hit = 1'b0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if ((5'(k) < length) && (grow_eff || (5'(k) != length - 5'd1)) &&
          (seg_x[k] == next_x) && (seg_y[k] == next_y))
        self_hit = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      length    <= 5'd3;
      cur_dir   <= DIR_RIGHT;
      game_over <= 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin
        seg_x[k] <= (k < 3) ? 6'(GRID_W / 2 - k) : 6'd0;
        seg_y[k] <= 6'(GRID_H / 2);
      end
    end else if (bus.move_i && !game_over) begin
      if (wall_hit || self_hit) begin
        game_over <= 1'b1;
      end else begin
        seg_x[0] <= next_x;
        seg_y[0] <= next_y;
        for (int k = 1; k < MAX_LEN; k++) begin
          seg_x[k] <= seg_x[k-1];
          seg_y[k] <= seg_y[k-1];
        end
        cur_dir <= eff_dir;
        if (grow_eff) length <= length + 5'd1;
      end
    end
  end

  logic [5:0] s1_cx, s1_cy;
  logic       s1_valid, s1_de;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_cx    <= 6'd0;
      s1_cy    <= 6'd0;
      s1_valid <= 1'b0;
      s1_de    <= 1'b0;
    end else begin
      s1_cx    <= 6'(bus.pixel_x_i >> SHIFT);
      s1_cy    <= 6'(bus.pixel_y_i >> SHIFT);
      s1_valid <= (bus.pixel_x_i < PIX_W) && (bus.pixel_y_i < PIX_H);
      s1_de    <= bus.display_enable_i;
    end
  end

  logic draw, hit_head, hit_body, hit_apple, hit_border;

  always_comb begin
    draw      = s1_de && s1_valid;
    hit_head  = (seg_x[0] == s1_cx) && (seg_y[0] == s1_cy);
    hit_body  = 1'b0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if ((5'(k) < length) && (seg_x[k] == s1_cx) && (seg_y[k] == s1_cy))
        hit_body = 1'b1;
    end
    hit_apple = (bus.apple_x_i == s1_cx) && (bus.apple_y_i == s1_cy);
`ifdef WRAP_AROUND_EN
    hit_border = 1'b0;
`else
    hit_border = (s1_cx == 6'd0) || (s1_cx == LAST_COL) ||
                 (s1_cy == 6'd0) || (s1_cy == LAST_ROW);
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bus.display_enable_o <= 1'b0;
      bus.head_snake_gfx_o <= 1'b0;
      bus.body_snake_gfx_o <= 1'b0;
      bus.apple_gfx_o      <= 1'b0;
      bus.border_gfx_o     <= 1'b0;
    end else begin
      bus.display_enable_o <= s1_de;
      bus.head_snake_gfx_o <= draw && hit_head;
      bus.body_snake_gfx_o <= draw && hit_body;
      bus.apple_gfx_o      <= draw && hit_apple;
      bus.border_gfx_o     <= draw && hit_border;
    end
  end

  assign bus.length_o    = length;
  assign bus.game_over_o = game_over;
endmodule

// File: tb/tb_snake_pixel_mapper.sv
// Self-checking bench for snake_pixel_mapper: table-driven pixel vectors through a
// scoreboard queue, plus move sequences for growth, reversal, tail chase and walls.
`timescale 1ns/1ps
module tb_snake_pixel_mapper;
`ifdef WRAP_AROUND_EN
  localparam bit BORDER_ON = 1'b0;
`else
  localparam bit BORDER_ON = 1'b1;
`endif

  typedef struct {
    string name;
    int    px;
    int    py;
    bit    de;
    bit    head;
    bit    body;
    bit    apple;
    bit    border;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   issue  = 1'b0;
  bit   v1     = 1'b0;
  bit   v2     = 1'b0;
  vec_t sb_q[$];

  always #5 clk = ~clk;

  snake_pixel_mapper_if bus ();

  snake_pixel_mapper dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Two-stage marker shift tracks which output cycles carry a queued pixel.
  always @(posedge clk) begin
    v1 <= issue;
    v2 <= v1;
  end

  always @(negedge clk) begin
    if (v2) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_underflow", 1, 0);
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        checkOutput({e.name, "_de"},     int'(bus.display_enable_o), int'(e.de));
        checkOutput({e.name, "_head"},   int'(bus.head_snake_gfx_o), int'(e.head));
        checkOutput({e.name, "_body"},   int'(bus.body_snake_gfx_o), int'(e.body));
        checkOutput({e.name, "_apple"},  int'(bus.apple_gfx_o),      int'(e.apple));
        checkOutput({e.name, "_border"}, int'(bus.border_gfx_o),     int'(e.border));
      end
    end
  end

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    bus.pixel_x_i        = 10'(v.px);
    bus.pixel_y_i        = 10'(v.py);
    bus.display_enable_i = v.de;
    issue                = 1'b1;
    sb_q.push_back(v);
  endtask

  task automatic endStream();
    int budget;
    @(negedge clk);
    issue                = 1'b0;
    bus.display_enable_i = 1'b0;
    budget = 10;
    while (sb_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb_q.size() != 0) begin
      checkOutput("sb_drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  // Apple is parked at (3,4) during probes; border follows the grid ring model.
  task automatic probeCell(input string name, input int cx, input int cy,
                           input bit head, input bit body);
    vec_t v;
    v.name   = name;
    v.px     = cx * 16 + 3;
    v.py     = cy * 16 + 5;
    v.de     = 1'b1;
    v.head   = head;
    v.body   = body;
    v.apple  = (cx == 3) && (cy == 4);
    v.border = BORDER_ON && (cx == 0 || cx == 39 || cy == 0 || cy == 29);
    applyStimulus(v);
    endStream();
  endtask

  task automatic doMove(input int dir, input bit grow);
    @(negedge clk);
    bus.move_i = 1'b1;
    bus.dir_i  = 2'(dir);
    bus.grow_i = grow;
    @(negedge clk);
    bus.move_i = 1'b0;
    bus.grow_i = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n                = 1'b0;
    issue                = 1'b0;
    bus.move_i           = 1'b0;
    bus.grow_i           = 1'b0;
    bus.dir_i            = 2'd1;
    bus.pixel_x_i        = 10'd320;
    bus.pixel_y_i        = 10'd240;
    bus.display_enable_i = 1'b1;
    bus.apple_x_i        = 6'd20;
    bus.apple_y_i        = 6'd15;
    repeat (3) @(negedge clk);
    checkOutput("rst_de",        int'(bus.display_enable_o), 0);
    checkOutput("rst_head",      int'(bus.head_snake_gfx_o), 0);
    checkOutput("rst_apple",     int'(bus.apple_gfx_o),      0);
    checkOutput("rst_length",    int'(bus.length_o),         3);
    checkOutput("rst_game_over", int'(bus.game_over_o),      0);
    rst_n                = 1'b1;
    bus.display_enable_i = 1'b0;
    bus.apple_x_i        = 6'd3;
    bus.apple_y_i        = 6'd4;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vt [14];
    vt[0]  = '{"head_center",   320, 240, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{"body_tail",     300, 240, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{"body_mid",      310, 250, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{"border_left",     5, 100, 1'b1, 1'b0, 1'b0, 1'b0, BORDER_ON};
    vt[4]  = '{"border_de_off",   5, 100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{"apple_tl",       48,  64, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{"apple_br",       63,  79, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[7]  = '{"apple_miss",     64,  64, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{"border_corner", 639, 479, 1'b1, 1'b0, 1'b0, 1'b0, BORDER_ON};
    vt[9]  = '{"outside_x",     640,   0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[10] = '{"outside_y",     100, 480, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[11] = '{"beyond_tail",   287, 240, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[12] = '{"ahead_head",    336, 240, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[13] = '{"border_top",    200,  15, 1'b1, 1'b0, 1'b0, 1'b0, BORDER_ON};

    bus.pixel_x_i        = 10'd0;
    bus.pixel_y_i        = 10'd0;
    bus.display_enable_i = 1'b0;
    bus.move_i           = 1'b0;
    bus.dir_i            = 2'd1;
    bus.grow_i           = 1'b0;
    bus.apple_x_i        = 6'd3;
    bus.apple_y_i        = 6'd4;

    $display("[TB] reset and pixel vector table");
    doReset();
    for (int i = 0; i < 14; i++) applyStimulus(vt[i]);
    endStream();

    @(negedge clk);
    bus.apple_x_i = 6'd20;
    bus.apple_y_i = 6'd15;
    applyStimulus('{"head_apple_overlap", 320, 240, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
    endStream();
    bus.apple_x_i = 6'd3;
    bus.apple_y_i = 6'd4;

    $display("[TB] growth and reversal");
    doMove(1, 1'b0);
    doMove(1, 1'b1);
    doMove(1, 1'b0);
    checkOutput("grow_length", int'(bus.length_o), 4);
    probeCell("grow_head",     23, 15, 1'b1, 1'b0);
    probeCell("grow_neck",     22, 15, 1'b0, 1'b1);
    probeCell("grow_tail",     20, 15, 1'b0, 1'b1);
    probeCell("grow_past",     19, 15, 1'b0, 1'b0);
    doMove(3, 1'b0);
    probeCell("reverse_head",  24, 15, 1'b1, 1'b0);
    probeCell("reverse_neck",  23, 15, 1'b0, 1'b1);
    probeCell("reverse_vacated", 20, 15, 1'b0, 1'b0);
    checkOutput("reverse_length",    int'(bus.length_o),    4);
    checkOutput("reverse_game_over", int'(bus.game_over_o), 0);

    $display("[TB] tail chase and self hit");
    doReset();
    doMove(1, 1'b1);
    doMove(0, 1'b0);
    doMove(3, 1'b0);
    doMove(2, 1'b0);
    checkOutput("tail_chase_game_over", int'(bus.game_over_o), 0);
    probeCell("tail_chase_head", 20, 15, 1'b1, 1'b0);
    probeCell("tail_chase_body", 20, 14, 1'b0, 1'b1);
    doMove(1, 1'b1);
    checkOutput("self_hit_game_over", int'(bus.game_over_o), 1);
    checkOutput("self_hit_length",    int'(bus.length_o),    4);
    probeCell("self_hit_head_kept", 20, 15, 1'b1, 1'b0);
    probeCell("self_hit_body_kept", 21, 15, 1'b0, 1'b1);

    $display("[TB] long run right with saturating growth");
    doReset();
    for (int i = 0; i < 18; i++) doMove(1, 1'b1);
    checkOutput("run18_game_over", int'(bus.game_over_o), 0);
    checkOutput("run18_length",    int'(bus.length_o),    16);
    probeCell("run18_head", 38, 15, 1'b1, 1'b0);
    probeCell("run18_body", 37, 15, 1'b0, 1'b1);
`ifdef WRAP_AROUND_EN
    doMove(1, 1'b0);
    doMove(1, 1'b0);
    checkOutput("wrap_game_over", int'(bus.game_over_o), 0);
    probeCell("wrap_head",     0, 15, 1'b1, 1'b0);
    probeCell("wrap_body",    39, 15, 1'b0, 1'b1);
    probeCell("wrap_no_ring",  0,  0, 1'b0, 1'b0);
`else
    doMove(1, 1'b0);
    checkOutput("wall_game_over", int'(bus.game_over_o), 1);
    doMove(2, 1'b1);
    checkOutput("wall_sticky",    int'(bus.game_over_o), 1);
    checkOutput("wall_length",    int'(bus.length_o),    16);
    probeCell("wall_head_kept", 38, 15, 1'b1, 1'b0);
    probeCell("wall_no_move",   38, 16, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
